load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port START, input, 1 bit: request strobe, sampled only in IDLE.
REQ-004 SHALL have port IS_STORE, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port OP, input, 3 bits: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL have port ADDR, input, 32 bits: byte address.
REQ-007 SHALL have port WDATA, input, 32 bits: store data, right-aligned.
REQ-008 SHALL have port BUSY, output, 1 bit: high in every non-IDLE state.
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port ERR, output, 1 bit: valid with DONE; 1 = request rejected.
REQ-011 SHALL have port LOAD_DATA, output, 32 bits: registered, extended load result.
REQ-012 SHALL have port MRd, output, 1 bit: memory read enable.
REQ-013 SHALL have port MWrt, output, 1 bit: memory write enable.
REQ-014 SHALL have port MEM_ADDR, output, 32 bits: word-aligned byte address to memory.
REQ-015 SHALL have port MEM_WDATA, output, 32 bits: full-word write data.
REQ-016 SHALL have port MEM_RDATA, input, 32 bits: combinational read data from memory.

Function
REQ-017 SHALL implement the states IDLE, LOAD, STORE_RD, STORE_WR and RESP.
REQ-018 In IDLE with START=1, SHALL latch IS_STORE, OP, ADDR and WDATA.
REQ-019 From IDLE with START=1, SHALL go to LOAD for a valid load, STORE_WR for SW, STORE_RD for SB/SH, and RESP with ERR=1 for an invalid request.
REQ-020 SHALL treat as invalid: load OP 011/110/111; store OP[2]=1 or OP=011; halfword with ADDR[0]=1; word with ADDR[1:0]!=00.
REQ-021 An invalid request SHALL cause no MRd/MWrt assertion.
REQ-022 LOAD SHALL assert MRd=1 and register the extracted byte/halfword/word into LOAD_DATA at the edge leaving LOAD, then go to RESP.
REQ-023 Extraction SHALL use little-endian lane order: byte n occupies bits 8n+7:8n, lane chosen by ADDR[1:0], halfword by ADDR[1].
REQ-024 B/H loads SHALL sign-extend; BU/HU loads SHALL zero-extend.
REQ-025 STORE_RD SHALL assert MRd=1, capture MEM_RDATA into a merge register, then go to STORE_WR.
REQ-026 STORE_WR SHALL assert MWrt=1 with MEM_WDATA as the merge word with the target lane(s) replaced by WDATA[7:0] or WDATA[15:0]; for SW, MEM_WDATA = WDATA; then go to RESP.
REQ-027 In LOAD/STORE_RD/STORE_WR, MEM_ADDR SHALL be {ADDR[31:2],2'b00}; otherwise MEM_ADDR=0, MEM_WDATA=0, MRd=0, MWrt=0.
REQ-028 MRd and MWrt SHALL never be high in the same cycle.
REQ-029 RESP SHALL assert DONE=1 for exactly one cycle, then go to IDLE.
REQ-030 ERR SHALL be 0 whenever DONE=0.
REQ-031 Latency from the edge sampling START to the DONE cycle SHALL be: 2 cycles for loads and SW, 3 cycles for SB/SH, 1 cycle for an error.
REQ-032 START while BUSY SHALL be ignored, with no queuing.
REQ-033 A new START SHALL be accepted in the first IDLE cycle after RESP.
REQ-034 LOAD_DATA SHALL change only on completion of a valid load; it SHALL hold across stores and errors.
REQ-035 Outputs SHALL be decoded from state and registers only, never combinationally from START.

Reset
REQ-036 RESET=1 at a rising edge SHALL force IDLE and clear LOAD_DATA, the latched request and the merge register to 0, overriding any in-flight operation.
REQ-037 After reset, SHALL output BUSY=0, DONE=0, ERR=0, MRd=0, MWrt=0, MEM_ADDR=0 and MEM_WDATA=0 until the next accepted START.
REQ-038 A request aborted by reset SHALL never produce DONE.

Verification
REQ-039 Memory word 0x40 = 0x8899AABB; LB at ADDR=0x42 -> one MRd cycle with MEM_ADDR=0x40; DONE 2 cycles after START; LOAD_DATA=0xFFFFFF99, ERR=0.
REQ-040 Same memory contents; LHU at ADDR=0x42 -> LOAD_DATA=0x00008899; LW at 0x40 -> LOAD_DATA=0x8899AABB.
REQ-041 Word 0x10 = 0x11223344; SB at ADDR=0x11 with WDATA=0x000000EE -> MRd cycle, then MWrt cycle with MEM_WDATA=0x1122EE44; DONE 3 cycles after START; LOAD_DATA unchanged.
REQ-042 LW at ADDR=0x13 and SH at ADDR=0x01 -> DONE and ERR=1 one cycle after START; MRd=MWrt=0 throughout; memory unchanged.
REQ-043 START held high continuously over back-to-back SW -> exactly one request per IDLE visit; START during BUSY ignored.
REQ-044 RESET asserted in the STORE_RD cycle of an SH -> IDLE next cycle, no MWrt, no DONE, all outputs 0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request and memory bus between a requester and the load/store unit.
// slave = the unit itself; master = the requester/memory side driving it.
interface load_store_unit_if;
    logic        START;
    logic        IS_STORE;
    logic [2:0]  OP;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] LOAD_DATA;
    logic        MRd;
    logic        MWrt;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    modport master (
        output START, IS_STORE, OP, ADDR, WDATA, MEM_RDATA,
        input  BUSY, DONE, ERR, LOAD_DATA, MRd, MWrt, MEM_ADDR, MEM_WDATA
    );

    modport slave (
        input  START, IS_STORE, OP, ADDR, WDATA, MEM_RDATA,
        output BUSY, DONE, ERR, LOAD_DATA, MRd, MWrt, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store engine with read-modify-write for sub-word stores.
// Latency 2 (loads, SW), 3 (SB/SH), 1 (rejected); START is dropped while BUSY.
module load_store_unit (
    input  logic             CLK,
    input  logic             RESET,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE_RD, STORE_WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        is_store_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] load_data_q;
    logic        err_q;

    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_ext;
    logic [31:0] st_word;
    logic [31:0] word_addr;

    // Request legality is judged on the live inputs so IDLE can branch directly.
    always_comb begin
        req_err = 1'b0;
        if (bus.IS_STORE)
            req_err = bus.OP[2] || (bus.OP[1:0] == 2'b11);
        else
            req_err = (bus.OP == 3'b011) || (bus.OP == 3'b110) || (bus.OP == 3'b111);
        if ((bus.OP[1:0] == 2'b01) && bus.ADDR[0])
            req_err = 1'b1;
        if ((bus.OP[1:0] == 2'b10) && (bus.ADDR[1:0] != 2'b00))
            req_err = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (!bus.IS_STORE)
                        state_nxt = LOAD;
                    else if (bus.OP[1:0] == 2'b10)
                        state_nxt = STORE_WR;
                    else
                        state_nxt = STORE_RD;
                end
            end
            LOAD:     state_nxt = RESP;
            STORE_RD: state_nxt = STORE_WR;
            STORE_WR: state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            is_store_q  <= 1'b0;
            op_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            merge_q     <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            if ((state == IDLE) && bus.START) begin
                is_store_q <= bus.IS_STORE;
                op_q       <= bus.OP;
                addr_q     <= bus.ADDR;
                wdata_q    <= bus.WDATA;
                err_q      <= req_err;
            end
            if (state == LOAD)
                load_data_q <= ld_ext;
            if (state == STORE_RD)
                merge_q <= bus.MEM_RDATA;
        end
    end

    // Little-endian lane extraction; op_q[2] selects zero- over sign-extension.
    always_comb begin
        byte_sel = bus.MEM_RDATA[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? bus.MEM_RDATA[31:16] : bus.MEM_RDATA[15:0];
        case (op_q[1:0])
            2'b00:   ld_ext = {{24{~op_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{16{~op_q[2] & half_sel[15]}}, half_sel};
            default: ld_ext = bus.MEM_RDATA;
        endcase
    end

    always_comb begin
        st_word = merge_q;
        case (op_q[1:0])
            2'b00:   st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: st_word = wdata_q;
        endcase
    end

    assign word_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        bus.BUSY      = (state != IDLE);
        bus.DONE      = 1'b0;
        bus.ERR       = 1'b0;
        bus.MRd       = 1'b0;
        bus.MWrt      = 1'b0;
        bus.MEM_ADDR  = 32'h0;
        bus.MEM_WDATA = 32'h0;
        bus.LOAD_DATA = load_data_q;
        case (state)
            LOAD, STORE_RD: begin
                bus.MRd      = 1'b1;
                bus.MEM_ADDR = word_addr;
            end
            STORE_WR: begin
                bus.MWrt      = is_store_q;
                bus.MEM_ADDR  = word_addr;
                bus.MEM_WDATA = is_store_q ? st_word : 32'h0;
            end
            RESP: begin
                bus.DONE = 1'b1;
                bus.ERR  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a word-addressed memory model.
module tb_load_store_unit;

    typedef struct {
        bit          err;
        logic [31:0] ld;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] rd_addr;
        int          start;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    load_store_unit_if bus();

    load_store_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    exp_t resp_q[$];
    wr_t  wq[$];

    logic [31:0] mem [0:63];
    logic        mem_ready = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    assign bus.MEM_RDATA = mem[bus.MEM_ADDR[7:2]];

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h00005566;
            mem[4]  <= 32'h11223344;
            mem[16] <= 32'h8899AABB;
            mem_ready <= 1'b1;
        end else if (bus.MWrt) begin
            mem[bus.MEM_ADDR[7:2]] <= bus.MEM_WDATA;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    function automatic exp_t mk(bit err, logic [31:0] ld, int lat, int nrd, int nwr, logic [31:0] ra);
        exp_t e;
        e.err = err; e.ld = ld; e.lat = lat; e.n_rd = nrd; e.n_wr = nwr; e.rd_addr = ra; e.start = 0;
        return e;
    endfunction

    // Monitor: compares every memory access and completion against the queues.
    always @(negedge CLK) begin
        if (RESET) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (bus.MRd && bus.MWrt) fail("mrd_mwrt_overlap");
            if (bus.ERR && !bus.DONE) fail("err_without_done");
            if (bus.MRd) begin
                rd_cnt++;
                if (resp_q.size() > 0) chk("mem_addr_rd", bus.MEM_ADDR, resp_q[0].rd_addr);
                else fail("unexpected_mrd");
            end
            if (bus.MWrt) begin
                wr_cnt++;
                if (wq.size() > 0) begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("mem_addr_wr", bus.MEM_ADDR, w.a);
                    chk("mem_wdata", bus.MEM_WDATA, w.d);
                end else fail("unexpected_mwrt");
            end
            if (bus.DONE) begin
                if (resp_q.size() > 0) begin
                    exp_t e;
                    e = resp_q.pop_front();
                    chk("err", 32'(bus.ERR), 32'(e.err));
                    chk("load_data", bus.LOAD_DATA, e.ld);
                    chk("latency", cyc - e.start + 1, e.lat);
                    chk("mrd_cycles", rd_cnt, e.n_rd);
                    chk("mwrt_cycles", wr_cnt, e.n_wr);
                end else fail("unexpected_done");
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((resp_q.size() != 0) && (n < 30)) begin
            @(posedge CLK);
            n++;
        end
        chk("pending_responses", resp_q.size(), 0);
        chk("pending_writes", wq.size(), 0);
        resp_q.delete();
        wq.delete();
    endtask

    task automatic issue(input bit st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input exp_t e);
        @(negedge CLK);
        bus.START = 1'b1; bus.IS_STORE = st; bus.OP = op; bus.ADDR = a; bus.WDATA = wd;
        e.start = cyc + 1;
        resp_q.push_back(e);
        @(negedge CLK);
        bus.START = 1'b0;
        chk("busy_after_start", 32'(bus.BUSY), 32'd1);
        drain();
    endtask

    task automatic chk_idle_outputs(input logic [31:0] ld);
        chk("idle_busy", 32'(bus.BUSY), 0);
        chk("idle_done", 32'(bus.DONE), 0);
        chk("idle_err", 32'(bus.ERR), 0);
        chk("idle_mrd", 32'(bus.MRd), 0);
        chk("idle_mwrt", 32'(bus.MWrt), 0);
        chk("idle_mem_addr", bus.MEM_ADDR, 0);
        chk("idle_mem_wdata", bus.MEM_WDATA, 0);
        chk("idle_load_data", bus.LOAD_DATA, ld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus.START = 1'b0; bus.IS_STORE = 1'b0; bus.OP = 3'b000; bus.ADDR = 32'h0; bus.WDATA = 32'h0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk_idle_outputs(32'h0);

        // Loads: sign/zero extension and lane selection.
        issue(0, 3'b000, 32'h42, 32'h0, mk(0, 32'hFFFFFF99, 2, 1, 0, 32'h40));
        issue(0, 3'b101, 32'h42, 32'h0, mk(0, 32'h00008899, 2, 1, 0, 32'h40));
        issue(0, 3'b010, 32'h40, 32'h0, mk(0, 32'h8899AABB, 2, 1, 0, 32'h40));

        // SB merges into the byte-1 lane; LOAD_DATA must hold.
        wq.push_back('{32'h10, 32'h1122EE44});
        issue(1, 3'b000, 32'h11, 32'h000000EE, mk(0, 32'h8899AABB, 3, 1, 1, 32'h10));
        issue(0, 3'b100, 32'h11, 32'h0, mk(0, 32'h000000EE, 2, 1, 0, 32'h10));
        issue(0, 3'b001, 32'h40, 32'h0, mk(0, 32'hFFFFAABB, 2, 1, 0, 32'h40));

        // Rejected requests: misaligned and illegal funct3.
        issue(0, 3'b010, 32'h13, 32'h0, mk(1, 32'hFFFFAABB, 1, 0, 0, 32'h0));
        issue(1, 3'b001, 32'h01, 32'h1234, mk(1, 32'hFFFFAABB, 1, 0, 0, 32'h0));
        issue(0, 3'b011, 32'h40, 32'h0, mk(1, 32'hFFFFAABB, 1, 0, 0, 32'h0));
        issue(1, 3'b100, 32'h40, 32'h55, mk(1, 32'hFFFFAABB, 1, 0, 0, 32'h0));

        // SH into the upper halfword.
        wq.push_back('{32'h10, 32'h1234EE44});
        issue(1, 3'b001, 32'h12, 32'hABCD1234, mk(0, 32'hFFFFAABB, 3, 1, 1, 32'h10));
        issue(0, 3'b101, 32'h12, 32'h0, mk(0, 32'h00001234, 2, 1, 0, 32'h10));

        // START held high across three SWs; junk presented while busy must be ignored.
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            bus.START = 1'b1; bus.IS_STORE = 1'b1; bus.OP = 3'b010;
            bus.ADDR = 32'h20 + 32'(4 * k); bus.WDATA = 32'hCAFE0020 + 32'(4 * k);
            wq.push_back('{32'h20 + 32'(4 * k), 32'hCAFE0020 + 32'(4 * k)});
            e = mk(0, 32'h00001234, 2, 0, 1, 32'h0);
            e.start = cyc + 1;
            resp_q.push_back(e);
            @(negedge CLK);
            bus.IS_STORE = 1'b0; bus.OP = 3'b111; bus.ADDR = 32'h13;
            if (k == 2) bus.START = 1'b0;
            chk("b2b_busy", 32'(bus.BUSY), 32'd1);
            @(negedge CLK);
            @(negedge CLK);
        end
        drain();
        issue(0, 3'b010, 32'h24, 32'h0, mk(0, 32'hCAFE0024, 2, 1, 0, 32'h24));

        // Reset during the STORE_RD cycle of an SH aborts it silently.
        @(negedge CLK);
        bus.START = 1'b1; bus.IS_STORE = 1'b1; bus.OP = 3'b001; bus.ADDR = 32'h02; bus.WDATA = 32'h7777;
        @(posedge CLK);
        #1 bus.START = 1'b0; RESET = 1'b1;
        @(negedge CLK);
        chk("abort_mrd", 32'(bus.MRd), 32'd1);
        chk("abort_mem_addr", bus.MEM_ADDR, 32'h0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk_idle_outputs(32'h0);
        repeat (6) @(negedge CLK);
        chk("abort_mem_unchanged", mem[0], 32'h00005566);

        issue(0, 3'b000, 32'h40, 32'h0, mk(0, 32'hFFFFFFBB, 2, 1, 0, 32'h40));
        chk("mem40_intact", mem[16], 32'h8899AABB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
